// File: rtl/fetch_unit.sv
// Instruction prefetch queue: fetches one word per cycle from memory into a DEPTH-entry FIFO.
// Fetch-to-output latency 1 cycle; fetch stalls while the queue is full and not popping, and redirect flushes.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetchEn,
    input  logic        redirect,
    input  logic [15:0] redirectPC,
    output logic [15:0] readAdr,
    input  logic [15:0] readData,
    output logic [15:0] instr,
    output logic [15:0] instrPC,
    output logic        instrValid,
    input  logic        instrReady
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] word;
    } entry_t;

    entry_t        q_mem [DEPTH];
    entry_t        head_entry;
    logic [15:0]   pc_q, pc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign readAdr    = pc_q;
    assign instrValid = (count_q != '0);
    assign pop        = instrValid & instrReady;
    assign push       = fetchEn & ~redirect & ((count_q < DEPTH_C) | pop);
    assign head_entry = q_mem[head_q];
    assign instr      = instrValid ? head_entry.word : 16'h0000;
    assign instrPC    = instrValid ? head_entry.pc   : 16'h0000;

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            // A handshake in the same cycle is dropped along with the queue.
            pc_d    = redirectPC;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + 16'd1;
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[tail_q] <= {pc_q, readData};
        end
    end

endmodule
